// File: rtl/result_fifo_pkg.sv
// Shared constants and types for the result FIFO behind the (A+B)-(C+D) datapath.
package result_fifo_pkg;

   localparam int unsigned RES_W      = 9;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned DROP_W     = 8;

   typedef logic [RES_W-1:0]  result_t;
   typedef logic [DROP_W-1:0] drop_cnt_t;

endpackage

// File: rtl/result_fifo_if.sv
// Producer/consumer handshake and status bundle for result_fifo.
interface result_fifo_if
   import result_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   result_t          in_result;
   logic             in_valid;
   logic             clear;
   result_t          out_data;
   logic             out_valid;
   logic             out_ready;
   logic [PTR_W:0]   level;
   logic             full;
   logic             overflow;
   drop_cnt_t        drop_count;

   modport master (
      output in_result, in_valid, clear, out_ready,
      input  out_data, out_valid, level, full, overflow, drop_count
   );

   modport slave (
      input  in_result, in_valid, clear, out_ready,
      output out_data, out_valid, level, full, overflow, drop_count
   );

endinterface

// File: rtl/result_fifo_mem.sv
// DEPTH x RES_W storage: registered write port, combinational read port.
module result_fifo_mem
   import result_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_addr,
   input  result_t          wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output result_t          rd_data
);

   result_t mem_q [DEPTH];

   // Storage carries no reset; occupancy tracking makes stale entries invisible.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/result_fifo.sv
// Circular result FIFO with valid/ready output and saturating overflow accounting.
module result_fifo
   import result_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic          clock,
   input  logic          reset,
   result_fifo_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             valid_q;
   logic             full_q;
   logic             overflow_q;
   drop_cnt_t        drop_q;

   logic             push_c;
   logic             pop_c;
   logic             drop_c;
   logic [LVL_W-1:0] level_nxt_c;
   result_t          rd_data_c;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   always_comb begin
      pop_c       = valid_q & bus.out_ready;
      push_c      = bus.in_valid & (~full_q | pop_c);
      drop_c      = bus.in_valid & full_q & ~pop_c;
      level_nxt_c = level_q;
      if (push_c & ~pop_c) begin
         level_nxt_c = level_q + LVL_W'(1);
      end else if (pop_c & ~push_c) begin
         level_nxt_c = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         valid_q    <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (bus.clear) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         valid_q    <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         level_q <= level_nxt_c;
         valid_q <= (level_nxt_c != '0);
         full_q  <= (level_nxt_c == LVL_W'(DEPTH));
         if (drop_c) begin
            overflow_q <= 1'b1;
            if (drop_q != '1) begin
               drop_q <= drop_q + DROP_W'(1);
            end
         end
      end
   end

   result_fifo_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clock   (clock),
      .we      (push_c & ~bus.clear),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.in_result),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data_c)
   );

   // Head entry is masked to zero while empty so reset/clear present a clean bus.
   assign bus.out_data   = valid_q ? rd_data_c : '0;
   assign bus.out_valid  = valid_q;
   assign bus.level      = level_q;
   assign bus.full       = full_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_result_fifo.sv
// Scoreboard bench for result_fifo: queue-based reference model plus a decoupled output monitor.
module tb_result_fifo;
   import result_fifo_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clock;
   logic reset;

   result_fifo_if #(.DEPTH(DEPTH)) bus ();

   result_fifo #(.DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks;
   int errors;

   // Reference model: plain queue of held results plus sticky drop accounting.
   result_t mq[$];
   result_t sb_q[$];
   bit      m_ovf;
   int      m_drops;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("level", 32'(bus.level), 32'(mq.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
      if (mq.size() != 0) begin
         chk("head", 32'(bus.out_data), 32'(mq[0]));
      end
   endtask

   task automatic model_flush();
      mq.delete();
      sb_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   // One clock cycle: drive at posedge+1, check mid-cycle, advance the model.
   task automatic step(input logic v, input result_t d, input logic r, input logic c);
      bit pop;
      bit push;
      result_t tmp;
      bus.in_valid  = v;
      bus.in_result = d;
      bus.out_ready = r;
      bus.clear     = c;
      @(negedge clock);
      check_state();
      pop  = (mq.size() != 0) && r;
      push = v && ((mq.size() < DEPTH) || pop);
      if (c) begin
         model_flush();
      end else begin
         if (pop) tmp = mq.pop_front();
         if (push) begin
            mq.push_back(d);
            sb_q.push_back(d);
         end else if (v) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: every accepted output must match the next result the stimulus pushed.
   initial begin
      result_t exp_d;
      forever begin
         @(negedge clock);
         if (!reset && !bus.clear && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
               exp_d = sb_q.pop_front();
               chk("sb_data", 32'(bus.out_data), 32'(exp_d));
            end
         end
      end
   end

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_result = '0;
      bus.out_ready = 1'b0;
      bus.clear     = 1'b0;
      model_flush();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      reset = 1'b0;

      // Single push and pop with -10.
      step(1'b1, 9'h1F6, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b1, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);

      // Fill, overflow three times, then saturate the drop counter.
      for (int i = 1; i <= 4; i++) step(1'b1, result_t'(i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, result_t'($urandom), 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      chk("drop_3", 32'(bus.drop_count), 32'd3);
      for (int i = 0; i < 260; i++) step(1'b1, result_t'($urandom), 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      chk("drop_sat", 32'(bus.drop_count), 32'hFF);

      // Full with simultaneous push and pop, then drain and wrap.
      step(1'b1, 9'h0AA, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 9'h000, 1'b1, 1'b0);
      step(1'b1, 9'h005, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b1, 1'b0);

      // Back-pressure hold at level 2.
      step(1'b1, 9'h155, 1'b0, 1'b0);
      step(1'b1, 9'h0C3, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 9'h000, 1'b0, 1'b0);

      // Async reset between edges at level 3 with overflow set.
      step(1'b1, 9'h07E, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1;
      chk("areset_valid", 32'(bus.out_valid), 32'h0);
      chk("areset_level", 32'(bus.level), 32'h0);
      chk("areset_ovf", 32'(bus.overflow), 32'h0);
      chk("areset_drops", 32'(bus.drop_count), 32'h0);
      #1 reset = 1'b0;
      model_flush();
      @(posedge clock);
      #1;

      // Clear coinciding with a would-be drop.
      for (int i = 0; i < 5; i++) step(1'b1, result_t'($urandom), 1'b0, 1'b0);
      step(1'b1, 9'h1AB, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      chk("clear_drops", 32'(bus.drop_count), 32'h0);

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 99) < 55), result_t'($urandom),
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 79) == 0));
      end

      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 9'h000, 1'b1, 1'b0);
      chk("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
